// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply-unit controller: op codes, FSM state encoding, HI/LO width.
package mdu_pkg;

  localparam int HILO_W = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// Execute-stage op port plus multiplier handshake of the HI/LO controller.
interface mdu_hilo_ctrl_if;
  import mdu_pkg::*;

  logic                  op_valid;
  logic [2:0]            op;
  logic [HILO_W-1:0]     rs_data;
  logic [HILO_W-1:0]     rt_data;
  logic                  stall;
  logic                  done;
  logic                  err;
  logic [HILO_W-1:0]     hi;
  logic [HILO_W-1:0]     lo;
  logic                  mul_start;
  logic                  mul_signed;
  logic [HILO_W-1:0]     mul_a;
  logic [HILO_W-1:0]     mul_b;
  logic [2*HILO_W-1:0]   mul_z;
  logic                  mul_busy;

  // slave is the controller, master is the core/multiplier side
  modport slave (
    input  op_valid, op, rs_data, rt_data, mul_z, mul_busy,
    output stall, done, err, hi, lo, mul_start, mul_signed, mul_a, mul_b
  );

  modport master (
    output op_valid, op, rs_data, rt_data, mul_z, mul_busy,
    input  stall, done, err, hi, lo, mul_start, mul_signed, mul_a, mul_b
  );

endinterface

// File: rtl/hilo_regs.sv
// HI/LO register pair with MTHI/MTLO and product write ports.
// Optional macro HILO_FWD_EN forwards MTHI/MTLO data onto hi/lo in the write cycle.
module hilo_regs
  import mdu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [HILO_W-1:0]   wr_data,
  input  logic                prod_we,
  input  logic [2*HILO_W-1:0] prod,
  output logic [HILO_W-1:0]   hi,
  output logic [HILO_W-1:0]   lo
);

  logic [HILO_W-1:0] hi_reg;
  logic [HILO_W-1:0] lo_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (prod_we) begin
      hi_reg <= prod[2*HILO_W-1:HILO_W];
      lo_reg <= prod[HILO_W-1:0];
    end else begin
      if (hi_we) hi_reg <= wr_data;
      if (lo_we) lo_reg <= wr_data;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = hi_we ? wr_data : hi_reg;
  assign lo = lo_we ? wr_data : lo_reg;
`else
  assign hi = hi_reg;
  assign lo = lo_reg;
`endif

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Multiply-unit controller: issues MULT/MULTU to the pipelined multiplier, stalls the core, captures HI/LO.
// Optional macro HILO_FWD_EN (handled in hilo_regs) forwards MTHI/MTLO data in the write cycle.
module mdu_hilo_ctrl
  import mdu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  mdu_hilo_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  state_t            state_reg;
  logic [CW-1:0]     wait_cnt_reg;
  logic              mul_start_reg;
  logic              mul_signed_reg;
  logic              done_reg;
  logic              err_reg;
  logic [HILO_W-1:0] mul_a_reg;
  logic [HILO_W-1:0] mul_b_reg;

  logic idle;
  logic accept_mul;
  logic hi_we;
  logic lo_we;
  logic prod_we;

  // ops presented while stalled are dropped; the core re-presents them
  assign idle       = (state_reg == IDLE);
  assign accept_mul = idle && bus.op_valid && is_mul_op(bus.op);
  assign hi_we      = idle && bus.op_valid && (bus.op == OP_MTHI);
  assign lo_we      = idle && bus.op_valid && (bus.op == OP_MTLO);
  assign prod_we    = (state_reg == CAPTURE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      mul_start_reg  <= 1'b0;
      mul_signed_reg <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
    end else begin
      mul_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept_mul) begin
            mul_a_reg      <= bus.rs_data;
            mul_b_reg      <= bus.rt_data;
            mul_signed_reg <= (bus.op == OP_MULT);
            mul_start_reg  <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          // busy may still show its pre-start level for the first two cycles
          if (!bus.mul_busy && (wait_cnt_reg >= CW'(2))) begin
            state_reg <= CAPTURE;
          end else if (wait_cnt_reg == CW'(WAIT_MAX - 1)) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        CAPTURE: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.stall      = !idle;
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;
  assign bus.mul_start  = mul_start_reg;
  assign bus.mul_signed = mul_signed_reg;
  assign bus.mul_a      = mul_a_reg;
  assign bus.mul_b      = mul_b_reg;

  hilo_regs u_hilo_regs (
    .clk     (clk),
    .rst     (rst),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wr_data (bus.rs_data),
    .prod_we (prod_we),
    .prod    (bus.mul_z),
    .hi      (bus.hi),
    .lo      (bus.lo)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl with a behavioural multiplier and a HI/LO reference model.
module tb_mdu_hilo_ctrl;
  import mdu_pkg::*;

  localparam int WAIT_MAX = 15;

  logic clk;
  logic rst;
  mdu_hilo_ctrl_if bus();

  mdu_hilo_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  // Multiplier: busy six cycles after start, product valid once busy drops; hang keeps busy high.
  bit hang = 1'b0;
  int busy_left = 0;
  always @(posedge clk) begin
    if (bus.mul_start) begin
      bus.mul_busy <= 1'b1;
      bus.mul_z    <= {$urandom, $urandom};
      busy_left    <= 6;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1 && !hang) begin
        bus.mul_busy <= 1'b0;
        bus.mul_z <= bus.mul_signed ?
                     ({{32{bus.mul_a[31]}}, bus.mul_a} * {{32{bus.mul_b[31]}}, bus.mul_b}) :
                     ({32'd0, bus.mul_a} * {32'd0, bus.mul_b});
      end
    end
  end

  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    longint p;
    longint unsigned u;
    sa = a;
    sb = b;
    if (sgn) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    u = longint'({32'd0, a}) * longint'({32'd0, b});
    return u;
  endfunction

  // Presents one multiply, then tracks the stall window; returns observations for the caller to check.
  task automatic run_mul(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int stall_cyc, output int starts,
                         output int dones, output bit stable, output bit done_after);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = opc;
    bus.rs_data  = a;
    bus.rt_data  = b;
    @(negedge clk);
    if (inject) begin
      bus.op      = OP_MTLO;
      bus.rs_data = 32'hAAAA5555;
    end else begin
      bus.op_valid = 1'b0;
      bus.op       = OP_NONE;
    end
    stall_cyc = 0;
    starts    = 0;
    dones     = 0;
    stable    = 1'b1;
    for (int i = 0; i < 64 && bus.stall; i++) begin
      stall_cyc++;
      starts += int'(bus.mul_start);
      dones  += int'(bus.done);
      if (bus.mul_a !== a || bus.mul_b !== b || bus.mul_signed !== (opc == OP_MULT)) stable = 1'b0;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    done_after   = bus.done;
    $display("mul op=%0d a=%h b=%h stall=%0d hi=%h lo=%h err=%0d",
             opc, a, b, stall_cyc, bus.hi, bus.lo, bus.err);
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    bus.rs_data  = '0;
    bus.rt_data  = '0;
    bus.mul_busy = 1'b0;
    bus.mul_z    = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.stall, bus.done, bus.err, bus.mul_start, bus.mul_signed} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {bus.stall, bus.done, bus.err, bus.mul_start, bus.mul_signed});
    end
    n_checks++;
    if ({bus.hi, bus.lo, bus.mul_a, bus.mul_b} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h required 0", {bus.hi, bus.lo, bus.mul_a, bus.mul_b});
    end
    rst = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_mult_signed();
    int sc, st, dn;
    bit stb, da;
    run_mul(OP_MULT, 32'hFFFFFFFD, 32'h00000005, 1'b0, sc, st, dn, stb, da);
    n_checks++;
    if (sc != 9) begin n_fail++; $display("FAIL mult_stall_len: got %0d required 9", sc); end
    n_checks++;
    if (st != 1) begin n_fail++; $display("FAIL mult_start_pulses: got %0d required 1", st); end
    n_checks++;
    if (dn != 0 || da !== 1'b1) begin
      n_fail++; $display("FAIL mult_done_timing: got in_stall=%0d after=%0b required 0/1", dn, da);
    end
    n_checks++;
    if (!stb) begin n_fail++; $display("FAIL mult_operands_held: got 0 required 1"); end
    n_checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFF1) begin
      n_fail++; $display("FAIL mult_product: got %h_%h required ffffffff_fffffff1", bus.hi, bus.lo);
    end
    model_hi = 32'hFFFFFFFF;
    model_lo = 32'hFFFFFFF1;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL mult_done_one_cycle: got done=%0b err=%0b required 0/0", bus.done, bus.err);
    end
  endtask

  task automatic test_multu();
    int sc, st, dn;
    bit stb, da;
    run_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, sc, st, dn, stb, da);
    n_checks++;
    if (!stb || sc != 9) begin
      n_fail++; $display("FAIL multu_held_unsigned: got stable=%0b stall=%0d required 1/9", stb, sc);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      n_fail++; $display("FAIL multu_product: got %h_%h required fffffffe_00000001", bus.hi, bus.lo);
    end
    model_hi = 32'hFFFFFFFE;
    model_lo = 32'h00000001;
  endtask

  task automatic test_random_mul();
    int sc, st, dn;
    bit stb, da;
    logic [2:0]  opc;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      opc = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
      a   = $urandom;
      b   = (i == 0) ? 32'h80000000 : $urandom;
      if (i == 0) a = 32'h80000000;
      exp = ref_mul(opc == OP_MULT, a, b);
      run_mul(opc, a, b, 1'b0, sc, st, dn, stb, da);
      n_checks++;
      if ({bus.hi, bus.lo} !== exp || sc != 9 || st != 1 || da !== 1'b1 || !stb) begin
        n_fail++;
        $display("FAIL rand_mul_%0d: got %h stall=%0d starts=%0d done=%0b stable=%0b required %h/9/1/1/1",
                 i, {bus.hi, bus.lo}, sc, st, da, stb, exp);
      end
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [2:0]  opc;
    logic [31:0] d, exp_hi, exp_lo;
    logic        v;
    // fixed back-to-back pair first, then random writes, no-ops and unknown codes
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin v = 1'b1; opc = OP_MTHI; d = 32'h12345678; end
      else if (i == 1) begin v = 1'b1; opc = OP_MTLO; d = 32'h9ABCDEF0; end
      else begin
        v = 1'($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 4))
          0: opc = OP_MTHI;
          1: opc = OP_MTLO;
          2: opc = OP_NONE;
          default: opc = 3'($urandom_range(5, 7));
        endcase
        d = $urandom;
      end
      n_checks++;
      if (bus.hi !== model_hi || bus.lo !== model_lo || bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL mtx_state_%0d: got %h_%h stall=%0b required %h_%h stall=0",
                 i, bus.hi, bus.lo, bus.stall, model_hi, model_lo);
      end
      bus.op_valid = v;
      bus.op       = opc;
      bus.rs_data  = d;
      #1;
      exp_hi = model_hi;
      exp_lo = model_lo;
`ifdef HILO_FWD_EN
      if (v && opc == OP_MTHI) exp_hi = d;
      if (v && opc == OP_MTLO) exp_lo = d;
`endif
      n_checks++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
        n_fail++;
        $display("FAIL mtx_same_cycle_%0d: got %h_%h required %h_%h", i, bus.hi, bus.lo, exp_hi, exp_lo);
      end
      if (v && opc == OP_MTHI) model_hi = d;
      if (v && opc == OP_MTLO) model_lo = d;
      $display("mtx valid=%0b op=%0d data=%h", v, opc, d);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    n_checks++;
    if (bus.hi !== model_hi || bus.lo !== model_lo) begin
      n_fail++; $display("FAIL mtx_final: got %h_%h required %h_%h", bus.hi, bus.lo, model_hi, model_lo);
    end
  endtask

  task automatic test_ignore_during_stall();
    int sc, st, dn;
    bit stb, da;
    logic [63:0] exp;
    exp = ref_mul(1'b1, 32'h00012345, 32'hFFFF0003);
    run_mul(OP_MULT, 32'h00012345, 32'hFFFF0003, 1'b1, sc, st, dn, stb, da);
    n_checks++;
    if ({bus.hi, bus.lo} !== exp || sc != 9 || st != 1) begin
      n_fail++;
      $display("FAIL ignore_in_stall: got %h stall=%0d starts=%0d required %h/9/1", {bus.hi, bus.lo}, sc, st, exp);
    end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    @(negedge clk);
    n_checks++;
    if (bus.lo !== model_lo || bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL ignore_after: got lo=%h stall=%0b required %h/0", bus.lo, bus.stall, model_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int dn;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.rs_data  = $urandom;
    bus.rt_data  = $urandom;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL midrst_in_wait: got stall=%0b required 1", bus.stall); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.stall, bus.mul_start, bus.done} !== 3'b0 || {bus.hi, bus.lo, bus.mul_a, bus.mul_b} !== 128'd0) begin
      n_fail++;
      $display("FAIL midrst_abort: got flags=%b regs=%h required 0/0",
               {bus.stall, bus.mul_start, bus.done}, {bus.hi, bus.lo, bus.mul_a, bus.mul_b});
    end
    @(negedge clk);
    rst = 1'b1;
    model_hi = '0;
    model_lo = '0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dn += int'(bus.done) + int'(bus.stall);
    end
    n_checks++;
    if (dn != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.mul_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_late_result: got events=%0d hi=%h lo=%h busy=%0b required 0/0/0/0",
               dn, bus.hi, bus.lo, bus.mul_busy);
    end
    $display("reset mid-operation done");
  endtask

  task automatic test_timeout();
    int sc, st, dn;
    bit stb, da;
    logic [31:0] a, b;
    logic [63:0] exp;
    run_mul(OP_MTHI, 32'hC0FFEE00, 32'd0, 1'b0, sc, st, dn, stb, da);
    model_hi = 32'hC0FFEE00;
    n_checks++;
    if (sc != 0 || bus.hi !== model_hi || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL pre_timeout: got stall=%0d hi=%h err=%0b required 0/%h/0", sc, bus.hi, bus.err, model_hi);
    end
    hang = 1'b1;
    run_mul(OP_MULTU, $urandom, $urandom, 1'b0, sc, st, dn, stb, da);
    n_checks++;
    if (sc != WAIT_MAX + 1 || bus.err !== 1'b1 || da !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_exit: got stall=%0d err=%0b done=%0b required %0d/1/0", sc, bus.err, da, WAIT_MAX + 1);
    end
    n_checks++;
    if (bus.hi !== model_hi || bus.lo !== model_lo) begin
      n_fail++; $display("FAIL timeout_hilo: got %h_%h required %h_%h", bus.hi, bus.lo, model_hi, model_lo);
    end
    hang = 1'b0;
    a = $urandom;
    b = $urandom;
    exp = ref_mul(1'b1, a, b);
    run_mul(OP_MULT, a, b, 1'b0, sc, st, dn, stb, da);
    model_hi = exp[63:32];
    model_lo = exp[31:0];
    n_checks++;
    if (bus.err !== 1'b1 || {bus.hi, bus.lo} !== exp || sc != 9) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%0b prod=%h stall=%0d required 1/%h/9", bus.err, {bus.hi, bus.lo}, exp, sc);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear: got %0b required 0", bus.err); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("timeout scenario done");
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu();
    test_random_mul();
    test_mthi_mtlo();
    test_ignore_during_stall();
    test_reset_mid_op();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
